// File: rtl/div_f_ctrl_pkg.sv
// div_f_ctrl shared types: FSM encoding,
// default widths and round-robin pick helper.
package div_f_ctrl_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int RES_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    DIV_F_CTRL_IDLE = 2'd0,
    DIV_F_CTRL_LOAD = 2'd1,
    DIV_F_CTRL_ITER = 2'd2,
    DIV_F_CTRL_RESP = 2'd3
  } state_t;

  function automatic logic [1:0] rr_pick(
    input logic [1:0] valid,
    input logic       last
  );
    logic [1:0] g;
    g = 2'b00;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/div_f_rr_arb2.sv
// div_f_rr_arb2: two-way round-robin grant.
// Pointer holds the last granted port.
module div_f_rr_arb2
  import div_f_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_q;

  assign grant = en ? rr_pick(valid, last_q)
                    : 2'b00;

  // remember winner so the other port wins next tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/div_f_ctrl.sv
// div_f_ctrl: sequencer/arbiter for div_f_core.
// Option macro: DIV_F_CTRL_DBZ_EN (zero-divisor bypass).
module div_f_ctrl
  import div_f_ctrl_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int RES_WIDTH = RES_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_dividend,
  input  logic [2*WIDTH-1:0]   req_divisor,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [RES_WIDTH-1:0] rsp_quo,
  output logic                 rsp_dbz,
  output logic                 busy,
  output logic                 core_rst,
  output logic [2*WIDTH-1:0]   core_init_val,
  output logic                 core_ld,
  output logic                 core_sl,
  input  logic                 core_done,
  input  logic [RES_WIDTH-1:0] core_res
);

  state_t               state;
  logic [WIDTH-1:0]     dividend_q;
  logic [WIDTH-1:0]     divisor_q;
  logic                 id_q;
  logic [RES_WIDTH-1:0] quo_q;
  logic [1:0]           grant;
  logic                 take;
  logic [WIDTH-1:0]     sel_dvd;
  logic [WIDTH-1:0]     sel_dvs;

  div_f_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (req_valid),
    .en    (state == DIV_F_CTRL_IDLE),
    .grant (grant)
  );

  assign take      = |grant;
  assign req_ready = grant;

  assign sel_dvd = grant[1]
    ? req_dividend[WIDTH +: WIDTH]
    : req_dividend[0 +: WIDTH];
  assign sel_dvs = grant[1]
    ? req_divisor[WIDTH +: WIDTH]
    : req_divisor[0 +: WIDTH];

  assign core_rst      = ~rst_n;
  assign core_init_val = {dividend_q, divisor_q};
  assign rsp_id        = id_q;
  assign rsp_quo       = quo_q;

`ifdef DIV_F_CTRL_DBZ_EN
  logic dbz_q;
  assign rsp_dbz = dbz_q;

  // divide-by-zero flag, set only on the bypass path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
    end else if (take) begin
      dbz_q <= (sel_dvs == '0);
    end
  end
`else
  assign rsp_dbz = 1'b0;
`endif

  // main sequencer; operands held from grant to handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DIV_F_CTRL_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      id_q       <= 1'b0;
      quo_q      <= '0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      core_ld    <= 1'b0;
      core_sl    <= 1'b0;
    end else begin
      unique case (state)
        DIV_F_CTRL_IDLE: begin
          if (take) begin
            dividend_q <= sel_dvd;
            divisor_q  <= sel_dvs;
            id_q       <= grant[1];
            busy       <= 1'b1;
`ifdef DIV_F_CTRL_DBZ_EN
            if (sel_dvs == '0) begin
              quo_q     <= '1;
              rsp_valid <= 1'b1;
              state     <= DIV_F_CTRL_RESP;
            end else begin
              core_ld <= 1'b1;
              state   <= DIV_F_CTRL_LOAD;
            end
`else
            core_ld <= 1'b1;
            state   <= DIV_F_CTRL_LOAD;
`endif
          end
        end
        DIV_F_CTRL_LOAD: begin
          core_ld <= 1'b0;
          core_sl <= 1'b1;
          state   <= DIV_F_CTRL_ITER;
        end
        DIV_F_CTRL_ITER: begin
          if (core_done) begin
            core_sl   <= 1'b0;
            quo_q     <= core_res;
            rsp_valid <= 1'b1;
            state     <= DIV_F_CTRL_RESP;
          end
        end
        DIV_F_CTRL_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= DIV_F_CTRL_IDLE;
          end
        end
        default: state <= DIV_F_CTRL_IDLE;
      endcase
    end
  end

endmodule
